prandom_coord: RTL

- Parametrised pseudo-random coordinate generator for the snake game's food placement.
- Next generation of the fixed 7-bit vertical XNOR LFSR: width, taps, wrap value and output range are configurable.
- Adds seed loading, rejection sampling to a range [0, LIMIT), and a 4-phase REQ/VALID handshake.
- One instance per axis; it sits between the game-control FSM and the food-position registers.

---
 rtl/prandom_coord.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prandom_coord.sv
// rtl/prandom_coord.sv - pseudo-random coordinate generator with range rejection and REQ/VALID handshake
module prandom_coord #(
    parameter int              WIDTH      = 7,
    parameter int              TAP_A      = 6,
    parameter int              TAP_B      = 5,
    parameter logic [WIDTH-1:0] WRAP_VALUE = WIDTH'(7'h6A),
    parameter int              LIMIT      = 100,
    parameter int              MAX_TRIES  = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             SEED_LOAD,
    input  logic [WIDTH-1:0] SEED,
    input  logic             REQ,
    output logic             VALID,
    output logic [WIDTH-1:0] OUT,
    output logic             TIMEOUT,
    output logic             BUSY,
    output logic             LFSR_DONE
);

    localparam int               TW         = $clog2(MAX_TRIES) + 1;
    // One extra bit so LIMIT == 2^WIDTH accepts every candidate.
    localparam logic [WIDTH:0]   LIMIT_EXT  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH-1:0] FALLBACK   = WIDTH'(LIMIT - 1);
    localparam logic [TW-1:0]    TRIES_LAST = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             lfsr_done_q, lfsr_done_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [WIDTH-1:0] lfsr_step;
    logic             accept;

    // LFSR next state: XNOR feedback, forced to zero at the wrap value; seed load wins over stepping.
    always_comb begin
        lfsr_step = (lfsr_q == WRAP_VALUE) ? '0
                  : {lfsr_q[WIDTH-2:0], ~(lfsr_q[TAP_A] ^ lfsr_q[TAP_B])};
        lfsr_d = lfsr_q;
        if (SEED_LOAD) begin
            // All-ones is the XNOR lock-up state, so it is mapped to zero.
            lfsr_d = (&SEED) ? '0 : SEED;
        end else if (CE || (state_q == ST_SEARCH)) begin
            lfsr_d = lfsr_step;
        end
        lfsr_done_d = (lfsr_q == WRAP_VALUE);
    end

    // Request handshake and rejection-sampling search over the current LFSR value.
    always_comb begin
        accept    = ({1'b0, lfsr_q} < LIMIT_EXT);
        state_d   = state_q;
        out_d     = out_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        tries_d   = tries_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    state_d = ST_SEARCH;
                    tries_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SEARCH: begin
                if (accept) begin
                    out_d     = lfsr_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else if (tries_q == TRIES_LAST) begin
                    out_d     = FALLBACK;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!REQ) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // All state and registered outputs; reset aborts any search immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            lfsr_done_q <= 1'b0;
            tries_q     <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            lfsr_done_q <= lfsr_done_d;
            tries_q     <= tries_d;
        end
    end

    assign VALID     = valid_q;
    assign OUT       = out_q;
    assign TIMEOUT   = timeout_q;
    assign BUSY      = busy_q;
    assign LFSR_DONE = lfsr_done_q;

endmodule
